irq_timer: RTL and testbench

IRQ_TIMER -- requirements
Module: irq_timer

---
 rtl/irq_timer.sv | 118 +++++++++++
 tb/tb_irq_timer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer.sv
// irq_timer: bus-mapped countdown timer raising a level interrupt.
// Define TIMER_ACK_EN to add the write-to-clear ACK register at addr 3.
module irq_timer #(
  parameter logic [31:0] CTRL_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic       en;
  logic [1:0] mode;

  assign en   = ctrl_q[0];
  assign mode = ctrl_q[2:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= CTRL_INIT[3:0];
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (mode == 2'b01) begin
          flag_d  = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
    endcase

    // Bus writes land after the FSM so they win any same-edge conflict
    if (we) begin
      case (addr)
        2'd0: begin
          ctrl_d = din[3:0];
          if (din[0]) flag_d = 1'b0;
        end
        2'd1: preset_d = din;
`ifdef TIMER_ACK_EN
        2'd3: flag_d = 1'b0;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0: dout = {28'b0, ctrl_q};
      2'd1: dout = preset_q;
      2'd2: dout = count_q;
`ifdef TIMER_ACK_EN
      2'd3: dout = {31'b0, flag_q};
`endif
      default: dout = '0;
    endcase
  end

  assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer: vector table, corner sequences and a
// randomized run checked against a behavioural model.
module tb_irq_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  irq_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // Behavioural model: phase of the timer life cycle
  localparam int PH_WAIT = 0;
  localparam int PH_ARM  = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_FIRE = 3;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  int          m_phase;

  function automatic void model_edge(
    input bit          r,
    input bit          w,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    logic [3:0]  c;
    logic [31:0] p;
    logic [31:0] n;
    bit          f;
    int          ph;
    if (r) begin
      m_ctrl   = 4'h0;
      m_preset = 0;
      m_count  = 0;
      m_flag   = 0;
      m_phase  = PH_WAIT;
      return;
    end
    c  = m_ctrl;
    p  = m_preset;
    n  = m_count;
    f  = m_flag;
    ph = m_phase;
    if (m_phase == PH_WAIT) begin
      if (m_ctrl[0]) ph = PH_ARM;
    end else if (m_phase == PH_ARM) begin
      n  = m_preset;
      ph = PH_RUN;
    end else if (m_phase == PH_RUN) begin
      if (!m_ctrl[0]) ph = PH_WAIT;
      else if (m_count >= 2) n = m_count - 1;
      else begin
        n  = 0;
        f  = 1;
        ph = PH_FIRE;
      end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin
        f  = 0;
        ph = PH_ARM;
      end else begin
        c[0] = 1'b0;
        ph   = PH_WAIT;
      end
    end
    if (w && a == 2'd0) begin
      c = d[3:0];
      if (d[0]) f = 0;
    end
    if (w && a == 2'd1) p = d;
`ifdef TIMER_ACK_EN
    if (w && a == 2'd3) f = 0;
`endif
    m_ctrl   = c;
    m_preset = p;
    m_count  = n;
    m_flag   = f;
    m_phase  = ph;
  endfunction

  function automatic logic [31:0] mdl_read(
    input logic [1:0] a
  );
    if (a == 2'd0) return {28'b0, m_ctrl};
    if (a == 2'd1) return m_preset;
    if (a == 2'd2) return m_count;
`ifdef TIMER_ACK_EN
    return {31'b0, m_flag};
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(
    input bit          r,
    input bit          w,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    reset = r;
    we    = w;
    addr  = a;
    din   = d;
    model_edge(r, w, a, d);
    @(posedge clk);
    #1;
    reset = 1'b0;
    we    = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 2'd0, 32'd0);
  endtask

  task automatic rd(
    input  logic [1:0]  a,
    output logic [31:0] v
  );
    addr = a;
    #1;
    v = dout;
  endtask

  typedef struct {
    bit          rst;
    bit          w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [1:0]  ra;
    logic [31:0] xd;
    bit          xi;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    bit          found;
    bit          r;
    bit          w;
    logic [1:0]  a;
    logic [1:0]  ra;
    logic [31:0] d;

    // One-shot, PRESET=5, IM=1: irq 7 edges after enable
    tbl[0]  = '{1, 0, 2'd0, 32'd0,     2'd0, 32'h0, 0};
    tbl[1]  = '{0, 1, 2'd1, 32'd5,     2'd1, 32'd5, 0};
    tbl[2]  = '{0, 1, 2'd0, 32'hF0_09, 2'd0, 32'h9, 0};
    tbl[3]  = '{0, 0, 2'd0, 32'd0,     2'd2, 32'd0, 0};
    tbl[4]  = '{0, 0, 2'd0, 32'd0,     2'd2, 32'd5, 0};
    tbl[5]  = '{0, 1, 2'd2, 32'd77,    2'd2, 32'd4, 0};
    tbl[6]  = '{0, 0, 2'd0, 32'd0,     2'd2, 32'd3, 0};
    tbl[7]  = '{0, 0, 2'd0, 32'd0,     2'd2, 32'd2, 0};
    tbl[8]  = '{0, 0, 2'd0, 32'd0,     2'd2, 32'd1, 0};
    tbl[9]  = '{0, 0, 2'd0, 32'd0,     2'd2, 32'd0, 1};
    tbl[10] = '{0, 0, 2'd0, 32'd0,     2'd0, 32'h8, 1};
    tbl[11] = '{0, 0, 2'd0, 32'd0,     2'd2, 32'd0, 1};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rst, tbl[i].w, tbl[i].a, tbl[i].d);
      rd(tbl[i].ra, v);
      chk($sformatf("tbl%0d dout", i), v, tbl[i].xd);
      chk($sformatf("tbl%0d irq", i),
          {31'b0, irq}, {31'b0, tbl[i].xi});
    end

    // Auto-reload PRESET=3: 1-cycle pulse every 5 cycles
    cyc(1, 0, 2'd0, 32'd0);
    cyc(0, 1, 2'd1, 32'd3);
    cyc(0, 1, 2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      idle();
      chk($sformatf("reload irq k%0d", k), {31'b0, irq},
          {31'b0, (k >= 5 && (k - 5) % 5 == 0)});
    end
    rd(2'd0, v);
    chk("reload ctrl", v, 32'hB);

    // Disable mid-count freezes COUNT; re-enable reloads
    cyc(1, 0, 2'd0, 32'd0);
    cyc(0, 1, 2'd1, 32'd6);
    cyc(0, 1, 2'd0, 32'h9);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(2'd2, v);
      if (v == 32'd3) found = 1;
      else idle();
    end
    chk("freeze reach3", {31'b0, found}, 32'd1);
    cyc(0, 1, 2'd0, 32'h8);
    for (int i = 0; i < 3; i++) idle();
    rd(2'd2, v);
    chk("freeze count", v, 32'd2);
    chk("freeze irq", {31'b0, irq}, 32'd0);
    cyc(0, 1, 2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      idle();
      if (k == 2) begin
        rd(2'd2, v);
        chk("reenable load", v, 32'd6);
      end
      chk($sformatf("reenable irq k%0d", k),
          {31'b0, irq}, {31'b0, (k == 8)});
    end

    // Masked pending irq, then unmask, then ack
    cyc(1, 0, 2'd0, 32'd0);
    cyc(0, 1, 2'd1, 32'd1);
    cyc(0, 1, 2'd0, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      idle();
      chk($sformatf("masked irq k%0d", k),
          {31'b0, irq}, 32'd0);
    end
`ifdef TIMER_ACK_EN
    rd(2'd3, v);
    chk("masked flag", v, 32'd1);
`endif
    cyc(0, 1, 2'd0, 32'h8);
    chk("unmask irq", {31'b0, irq}, 32'd1);
    cyc(0, 1, 2'd3, 32'd0);
`ifdef TIMER_ACK_EN
    chk("ack irq", {31'b0, irq}, 32'd0);
`else
    chk("noack irq", {31'b0, irq}, 32'd1);
`endif
    rd(2'd3, v);
    chk("ack read", v, 32'd0);

    // PRESET=0 behaves as 1: irq after 3 edges
    cyc(1, 0, 2'd0, 32'd0);
    cyc(0, 1, 2'd1, 32'd0);
    cyc(0, 1, 2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      idle();
      chk($sformatf("p0 irq k%0d", k),
          {31'b0, irq}, {31'b0, (k == 3)});
    end

    // Reset mid-count beats a same-cycle write
    cyc(1, 0, 2'd0, 32'd0);
    cyc(0, 1, 2'd1, 32'd6);
    cyc(0, 1, 2'd0, 32'h9);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(2'd2, v);
      if (v == 32'd4) found = 1;
      else idle();
    end
    chk("rst reach4", {31'b0, found}, 32'd1);
    cyc(1, 1, 2'd0, 32'h9);
    for (int i = 0; i < 3; i++) begin
      rd(2'(i), v);
      chk($sformatf("rst reg%0d", i), v, 32'd0);
    end
    chk("rst irq", {31'b0, irq}, 32'd0);
    for (int k = 0; k < 15; k++) idle();
    chk("rst no irq", {31'b0, irq}, 32'd0);
    rd(2'd2, v);
    chk("rst count", v, 32'd0);

    // Randomized run against the model
    cyc(1, 0, 2'd0, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 9) < 3);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 7);
      cyc(r, w, a, d);
      ra = 2'($urandom_range(0, 3));
      rd(ra, v);
      chk($sformatf("rnd%0d dout a%0d", i, ra),
          v, mdl_read(ra));
      chk($sformatf("rnd%0d irq", i), {31'b0, irq},
          {31'b0, m_flag & m_ctrl[3]});
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
